control_unit: RTL and testbench
===============================

# control_unit

Moore-type sequencing FSM for the pointcloud accumulator processor. It fetches instructions from the instruction ROM and decodes the 8-bit instruction register (`REG_IR`). It then drives every datapath control line: memory strobes, register write enables, bus source, increments, clears, comparator select and ALU operation. It sits between the IR/zero-flag outputs of the datapath and the datapath's control inputs.

## Interface
- No parameters. State register is 8 bits wide.
- `Clk` in 1: rising-edge clock.
- `Rstn` in 1: asynchronous, active-low reset.
- `z` in 1: datapath zero flag.
- `REG_IR` in 8: instruction register. `[7:4]` is the opcode; `[3:0]` is operand `n`.
- `iROMREAD` out 1: instruction ROM read at PC.
- `memREAD` out 1: data memory read.
- `memWRITE` out 1: data memory write.
- `wEN` out 14: register write enables.
  - `[0]` PC, `[1]` IR, `[2]` AR, `[3]` AC.
  - `[4..11]` R1–R8.
  - `[12]` TR, `[13]` OUT.
- `selAR` out 1: data address source. 0 selects AR; 1 selects R1.
- `busMUX` out 4: bus source.
  - 0 zero, 1 PC, 2 IROM data, 3 DMEM data, 4 AC.
  - 5–12 R1–R8, 13 TR.
  - 14–15 zero.
- `INC` out 6: increment enables. `[0]` PC, `[1]` AR, `[2..5]` R1–R4.
- `RST` out 5: clear enables. `[0]` AC, `[1..4]` R1–R4.
- `compMUX` out 3: compare operand. Value `k` selects R(k+1) against AC.
- `aluOP` out 3: 0 PASS, 1 ADD, 2 SUB, 3 MUL, 4 SHR, 5 SHL, 6 AND, 7 OR.

## Operation
- Every output is a pure decode of the current state. Outputs not listed for a state are 0.
- **INIT** (reset state): `RST`=5'b11111, then FETCH_1.
- **FETCH_1**: `iROMREAD`=1.
- **FETCH_2**: `busMUX`=2, `wEN[1]`, `INC[0]`.
- **FETCH_3**: no outputs asserted. Samples `REG_IR` and `z` and branches on the opcode:
  - 0 NOP: → FETCH_1.
  - 1 LDAC: LDAC_1 (`iROMREAD`) → LDAC_2 (`busMUX`=2, `wEN[2]`, `INC[0]`) → LDAC_3 (`memREAD`, `selAR`=0) → LDAC_4 (`busMUX`=3, `wEN[3]`).
  - 2 STAC: STAC_1 and STAC_2 are identical to LDAC_1/LDAC_2. STAC_3: `busMUX`=4, `memWRITE`.
  - 3 MVR: `busMUX`=4, `wEN[3+n]`.
  - 4 MVAC: `busMUX`=4+n, `wEN[3]`.
  - 5 ADD, 6 SUB, 7 MUL:
    - ALU_1: `busMUX`=4+n, `aluOP` = 1/2/3, `wEN[12]`.
    - ALU_2: `busMUX`=13, `wEN[3]`.
  - 8 INCR: `INC[1+n]`. Valid n is 1–4.
  - 9 CLR: `RST[n]`. n=0 clears AC; valid n is 0–4.
  - 10 JMP: J_1 (`iROMREAD`) → J_2 (`busMUX`=2, `wEN[0]`).
  - 11 JMPZ:
    - z=1: same sequence as JMP.
    - z=0: JZN_1 (`INC[0]`), which skips the operand byte.
  - 12 CMP: `compMUX`=n−1, `aluOP`=2. The datapath updates `z`.
  - 13 LDIND: LDI_1 (`memREAD`, `selAR`=1) → LDI_2 (`busMUX`=3, `wEN[3]`).
  - 14 OUT: `busMUX`=4, `wEN[13]`.
  - 15 END: → HALT. HALT asserts no outputs and remains there until reset.
- The last state of every instruction returns to FETCH_1.
- Register-indexed opcodes (3–7, 12) with n outside 1–8 act as NOP.
- INCR with n outside 1–4 acts as NOP; CLR with n outside 0–4 acts as NOP.
- Any unused state encoding → INIT.

## Timing
- One state per clock. `Rstn` low forces INIT immediately, mid-instruction included. The first FETCH_1 occurs on the first edge after `Rstn` rises.
- Cycles per instruction, including the 3 fetch cycles:
  - 4: NOP, MVR, MVAC, INCR, CLR, CMP, OUT, and JMPZ not-taken.
  - 5: ALU ops, JMP, JMPZ taken, LDIND.
  - 6: STAC.
  - 7: LDAC.
- `REG_IR` and `z` must be stable at the FETCH_3 edge. `z` is not used in any other state.
- Outputs change only after clock edges; there are no combinational paths from inputs to outputs.

## Configuration
- `CU_MUL_EN` defined: opcode 7 executes MUL (`aluOP`=3).
- `CU_MUL_EN` undefined: opcode 7 decodes as NOP (4 cycles) and `aluOP`=3 is never driven.

## Test plan
- Reset with `Rstn` low: `RST`=5'h1F and all other outputs 0. After release, `iROMREAD`=1 on the next cycle.
- `REG_IR`=8'h10: 7-cycle sequence. LDAC_2 asserts `wEN`=14'h0004 with `INC`=6'h01; LDAC_3 asserts `memREAD`; LDAC_4 asserts `busMUX`=3 with `wEN`=14'h0008.
- `REG_IR`=8'h20: STAC_3 asserts `memWRITE`=1 and `busMUX`=4, then returns to FETCH_1.
- `REG_IR`=8'h53: ALU_1 asserts `busMUX`=7, `aluOP`=1, `wEN[12]`; ALU_2 asserts `busMUX`=13, `wEN[3]`.
- `REG_IR`=8'hB0:
  - z=0: JZN_1 asserts `INC`=6'h01; 4 cycles total.
  - z=1: J_2 asserts `wEN`=14'h0001.
- `REG_IR`=8'hF0: HALT holds all outputs at 0 indefinitely. Asserting `Rstn` low mid-HALT → INIT.

Source files
------------

// File: rtl/control_unit_if.sv
// Control bundle between the sequencing FSM and the accumulator datapath.
// master = control unit (drives strobes/enables), slave = datapath (drives IR and zero flag).
interface control_unit_if;
   logic        z;
   logic [7:0]  REG_IR;
   logic        iROMREAD;
   logic        memREAD;
   logic        memWRITE;
   logic [13:0] wEN;
   logic        selAR;
   logic [3:0]  busMUX;
   logic [5:0]  INC;
   logic [4:0]  RST;
   logic [2:0]  compMUX;
   logic [2:0]  aluOP;

   modport master (
      input  z, REG_IR,
      output iROMREAD, memREAD, memWRITE, wEN, selAR, busMUX, INC, RST, compMUX, aluOP
   );

   modport slave (
      output z, REG_IR,
      input  iROMREAD, memREAD, memWRITE, wEN, selAR, busMUX, INC, RST, compMUX, aluOP
   );
endinterface

// File: rtl/control_unit.sv
// Moore sequencing FSM for the pointcloud accumulator: fetch, decode REG_IR, drive datapath controls.
// Define CU_MUL_EN to execute opcode 7 as MUL; otherwise opcode 7 behaves as NOP.
module control_unit (
   input  logic          Clk,
   input  logic          Rstn,
   control_unit_if.master cu
);

   localparam logic [7:0] S_INIT    = 8'd0;
   localparam logic [7:0] S_FETCH_1 = 8'd1;
   localparam logic [7:0] S_FETCH_2 = 8'd2;
   localparam logic [7:0] S_FETCH_3 = 8'd3;
   localparam logic [7:0] S_NOP_1   = 8'd4;
   localparam logic [7:0] S_LDAC_1  = 8'd5;
   localparam logic [7:0] S_LDAC_2  = 8'd6;
   localparam logic [7:0] S_LDAC_3  = 8'd7;
   localparam logic [7:0] S_LDAC_4  = 8'd8;
   localparam logic [7:0] S_STAC_1  = 8'd9;
   localparam logic [7:0] S_STAC_2  = 8'd10;
   localparam logic [7:0] S_STAC_3  = 8'd11;
   localparam logic [7:0] S_MVR_1   = 8'd12;
   localparam logic [7:0] S_MVAC_1  = 8'd13;
   localparam logic [7:0] S_ALU_1   = 8'd14;
   localparam logic [7:0] S_ALU_2   = 8'd15;
   localparam logic [7:0] S_INCR_1  = 8'd16;
   localparam logic [7:0] S_CLR_1   = 8'd17;
   localparam logic [7:0] S_J_1     = 8'd18;
   localparam logic [7:0] S_J_2     = 8'd19;
   localparam logic [7:0] S_JZN_1   = 8'd20;
   localparam logic [7:0] S_CMP_1   = 8'd21;
   localparam logic [7:0] S_LDI_1   = 8'd22;
   localparam logic [7:0] S_LDI_2   = 8'd23;
   localparam logic [7:0] S_OUT_1   = 8'd24;
   localparam logic [7:0] S_HALT    = 8'd25;

   logic [7:0] r_state;
   logic [7:0] w_next;
   logic [3:0] r_n;
   logic [2:0] r_aluop;

   logic [3:0] w_op;
   logic [3:0] w_n;
   logic       w_reg_ok;
   logic       w_inc_ok;
   logic       w_clr_ok;

   assign w_op     = cu.REG_IR[7:4];
   assign w_n      = cu.REG_IR[3:0];
   assign w_reg_ok = (w_n >= 4'd1) && (w_n <= 4'd8);
   assign w_inc_ok = (w_n >= 4'd1) && (w_n <= 4'd4);
   assign w_clr_ok = (w_n <= 4'd4);

   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) r_state <= S_INIT;
      else       r_state <= w_next;
   end

   // Operand and ALU op are latched at decode so outputs depend on state registers only.
   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         r_n     <= 4'd0;
         r_aluop <= 3'd0;
      end else if (r_state == S_FETCH_3) begin
         r_n     <= w_n;
         r_aluop <= cu.REG_IR[6:4] - 3'd4;
      end
   end

   always_comb begin
      w_next = S_INIT;
      case (r_state)
         S_INIT:    w_next = S_FETCH_1;
         S_FETCH_1: w_next = S_FETCH_2;
         S_FETCH_2: w_next = S_FETCH_3;
         S_FETCH_3: begin
            case (w_op)
               4'd0:  w_next = S_NOP_1;
               4'd1:  w_next = S_LDAC_1;
               4'd2:  w_next = S_STAC_1;
               4'd3:  w_next = w_reg_ok ? S_MVR_1  : S_NOP_1;
               4'd4:  w_next = w_reg_ok ? S_MVAC_1 : S_NOP_1;
               4'd5,
               4'd6:  w_next = w_reg_ok ? S_ALU_1  : S_NOP_1;
`ifdef CU_MUL_EN
               4'd7:  w_next = w_reg_ok ? S_ALU_1  : S_NOP_1;
`else
               4'd7:  w_next = S_NOP_1;
`endif
               4'd8:  w_next = w_inc_ok ? S_INCR_1 : S_NOP_1;
               4'd9:  w_next = w_clr_ok ? S_CLR_1  : S_NOP_1;
               4'd10: w_next = S_J_1;
               4'd11: w_next = cu.z ? S_J_1 : S_JZN_1;
               4'd12: w_next = w_reg_ok ? S_CMP_1  : S_NOP_1;
               4'd13: w_next = S_LDI_1;
               4'd14: w_next = S_OUT_1;
               default: w_next = S_HALT;
            endcase
         end
         S_LDAC_1:  w_next = S_LDAC_2;
         S_LDAC_2:  w_next = S_LDAC_3;
         S_LDAC_3:  w_next = S_LDAC_4;
         S_STAC_1:  w_next = S_STAC_2;
         S_STAC_2:  w_next = S_STAC_3;
         S_ALU_1:   w_next = S_ALU_2;
         S_J_1:     w_next = S_J_2;
         S_LDI_1:   w_next = S_LDI_2;
         S_HALT:    w_next = S_HALT;
         S_NOP_1, S_LDAC_4, S_STAC_3, S_MVR_1, S_MVAC_1, S_ALU_2, S_INCR_1,
         S_CLR_1, S_J_2, S_JZN_1, S_CMP_1, S_LDI_2, S_OUT_1:
                    w_next = S_FETCH_1;
         default:   w_next = S_INIT;
      endcase
   end

   always_comb begin
      cu.iROMREAD = 1'b0;
      cu.memREAD  = 1'b0;
      cu.memWRITE = 1'b0;
      cu.wEN      = 14'd0;
      cu.selAR    = 1'b0;
      cu.busMUX   = 4'd0;
      cu.INC      = 6'd0;
      cu.RST      = 5'd0;
      cu.compMUX  = 3'd0;
      cu.aluOP    = 3'd0;
      case (r_state)
         S_INIT:    cu.RST = 5'b11111;
         S_FETCH_1, S_LDAC_1, S_STAC_1, S_J_1:
                    cu.iROMREAD = 1'b1;
         S_FETCH_2: begin
            cu.busMUX = 4'd2;
            cu.wEN[1] = 1'b1;
            cu.INC[0] = 1'b1;
         end
         S_LDAC_2, S_STAC_2: begin
            cu.busMUX = 4'd2;
            cu.wEN[2] = 1'b1;
            cu.INC[0] = 1'b1;
         end
         S_LDAC_3:  cu.memREAD = 1'b1;
         S_LDAC_4, S_LDI_2: begin
            cu.busMUX = 4'd3;
            cu.wEN[3] = 1'b1;
         end
         S_STAC_3: begin
            cu.busMUX   = 4'd4;
            cu.memWRITE = 1'b1;
         end
         S_MVR_1: begin
            cu.busMUX           = 4'd4;
            cu.wEN[4'd3 + r_n]  = 1'b1;
         end
         S_MVAC_1: begin
            cu.busMUX = 4'd4 + r_n;
            cu.wEN[3] = 1'b1;
         end
         S_ALU_1: begin
            cu.busMUX  = 4'd4 + r_n;
            cu.aluOP   = r_aluop;
            cu.wEN[12] = 1'b1;
         end
         S_ALU_2: begin
            cu.busMUX = 4'd13;
            cu.wEN[3] = 1'b1;
         end
         S_INCR_1:  cu.INC[r_n[2:0] + 3'd1] = 1'b1;
         S_CLR_1:   cu.RST[r_n[2:0]] = 1'b1;
         S_J_2: begin
            cu.busMUX = 4'd2;
            cu.wEN[0] = 1'b1;
         end
         S_JZN_1:   cu.INC[0] = 1'b1;
         S_CMP_1: begin
            cu.compMUX = r_n[2:0] - 3'd1;
            cu.aluOP   = 3'd2;
         end
         S_LDI_1: begin
            cu.memREAD = 1'b1;
            cu.selAR   = 1'b1;
         end
         S_OUT_1: begin
            cu.busMUX  = 4'd4;
            cu.wEN[13] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction stream checked cycle-by-cycle against a per-instruction output-sequence model.
module tb_control_unit;

   typedef struct packed {
      logic        iROMREAD;
      logic        memREAD;
      logic        memWRITE;
      logic [13:0] wEN;
      logic        selAR;
      logic [3:0]  busMUX;
      logic [5:0]  INC;
      logic [4:0]  RST;
      logic [2:0]  compMUX;
      logic [2:0]  aluOP;
   } outs_t;

`ifdef CU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   localparam int HALT_CYCLES = 12;

   logic Clk;
   logic Rstn;
   control_unit_if cu_if ();

   control_unit dut (
      .Clk  (Clk),
      .Rstn (Rstn),
      .cu   (cu_if)
   );

   outs_t act;
   assign act = {cu_if.iROMREAD, cu_if.memREAD, cu_if.memWRITE, cu_if.wEN, cu_if.selAR,
                 cu_if.busMUX, cu_if.INC, cu_if.RST, cu_if.compMUX, cu_if.aluOP};

   outs_t exp_q[$];
   bit    chk_en;
   int    n_cmp;
   int    n_bad;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
      end
   endtask

   function automatic outs_t mk(input logic rom, input logic rd, input logic wr, input logic [13:0] wen,
                                input logic sel, input logic [3:0] bus, input logic [5:0] inc,
                                input logic [4:0] rst, input logic [2:0] cmp, input logic [2:0] alu);
      return {rom, rd, wr, wen, sel, bus, inc, rst, cmp, alu};
   endfunction

   // Expected output sequence of one whole instruction, fetch included.
   task automatic build(input logic [7:0] ir, input logic zv, output int len);
      int    op, n, start;
      bit    regv;
      outs_t o;
      op    = int'(ir[7:4]);
      n     = int'(ir[3:0]);
      regv  = (n >= 1 && n <= 8);
      start = exp_q.size();
      o = '0; o.iROMREAD = 1'b1;                              exp_q.push_back(o);
      o = '0; o.busMUX = 4'd2; o.wEN = 14'h0002; o.INC = 6'h01; exp_q.push_back(o);
      o = '0;                                                  exp_q.push_back(o);
      o = '0;
      if (op == 1 || op == 2) begin
         o.iROMREAD = 1'b1; exp_q.push_back(o);
         o = '0; o.busMUX = 4'd2; o.wEN = 14'h0004; o.INC = 6'h01; exp_q.push_back(o);
         o = '0;
         if (op == 1) begin
            o.memREAD = 1'b1; exp_q.push_back(o);
            o = '0; o.busMUX = 4'd3; o.wEN = 14'h0008; exp_q.push_back(o);
         end else begin
            o.busMUX = 4'd4; o.memWRITE = 1'b1; exp_q.push_back(o);
         end
      end else if (op == 3 && regv) begin
         o.busMUX = 4'd4; o.wEN = 14'(1 << (3 + n)); exp_q.push_back(o);
      end else if (op == 4 && regv) begin
         o.busMUX = 4'(4 + n); o.wEN = 14'h0008; exp_q.push_back(o);
      end else if ((op == 5 || op == 6 || (op == 7 && MUL_EN)) && regv) begin
         o.busMUX = 4'(4 + n); o.aluOP = 3'(op - 4); o.wEN = 14'h1000; exp_q.push_back(o);
         o = '0; o.busMUX = 4'd13; o.wEN = 14'h0008; exp_q.push_back(o);
      end else if (op == 8 && n >= 1 && n <= 4) begin
         o.INC = 6'(1 << (1 + n)); exp_q.push_back(o);
      end else if (op == 9 && n <= 4) begin
         o.RST = 5'(1 << n); exp_q.push_back(o);
      end else if (op == 10 || (op == 11 && zv)) begin
         o.iROMREAD = 1'b1; exp_q.push_back(o);
         o = '0; o.busMUX = 4'd2; o.wEN = 14'h0001; exp_q.push_back(o);
      end else if (op == 11) begin
         o.INC = 6'h01; exp_q.push_back(o);
      end else if (op == 12 && regv) begin
         o.compMUX = 3'(n - 1); o.aluOP = 3'd2; exp_q.push_back(o);
      end else if (op == 13) begin
         o.memREAD = 1'b1; o.selAR = 1'b1; exp_q.push_back(o);
         o = '0; o.busMUX = 4'd3; o.wEN = 14'h0008; exp_q.push_back(o);
      end else if (op == 14) begin
         o.busMUX = 4'd4; o.wEN = 14'h2000; exp_q.push_back(o);
      end else if (op == 15) begin
         for (int i = 0; i < HALT_CYCLES; i++) exp_q.push_back(o);
      end else begin
         exp_q.push_back(o);
      end
      len = exp_q.size() - start;
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL seq_underflow: got %h expected no active cycle (t=%0t)", act, $time);
         end else begin
            chk("cycle", 64'(act), 64'(exp_q.pop_front()));
         end
      end
   end

   // Runs one instruction; optionally pins one cycle to a literal and/or resets partway through.
   task automatic do_instr(input logic [7:0] ir, input logic zv, input bit mid_rst,
                           input int pin_idx, input outs_t pin, input string nm, input int exp_len);
      int len;
      int stop;
      build(ir, zv, len);
      if (exp_len >= 0) chk({nm, "_len"}, 64'(len), 64'(exp_len));
      cu_if.REG_IR = ir;
      cu_if.z      = zv;
      if (!Rstn) begin
         chk_en = 1'b1;
         Rstn   = 1'b1;
      end
      stop = mid_rst ? int'($urandom_range(len - 1, 1)) : len;
      for (int k = 0; k < stop; k++) begin
         @(negedge Clk);
         #1;
         if (k == pin_idx) chk(nm, 64'(act), 64'(pin));
      end
      if (mid_rst || ir[7:4] == 4'hF) begin
         chk_en = 1'b0;
         exp_q.delete();
         Rstn = 1'b0;
         #1;
         chk({nm, "_rst_async"}, 64'(act), 64'(mk(0, 0, 0, 14'h0, 0, 4'd0, 6'h0, 5'h1F, 3'd0, 3'd0)));
         @(negedge Clk);
         #1;
         chk({nm, "_rst_hold"}, 64'(act), 64'(mk(0, 0, 0, 14'h0, 0, 4'd0, 6'h0, 5'h1F, 3'd0, 3'd0)));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      outs_t none;
      none   = '0;
      n_cmp  = 0;
      n_bad  = 0;
      chk_en = 1'b0;
      Rstn   = 1'b0;
      cu_if.REG_IR = 8'h00;
      cu_if.z      = 1'b0;
      repeat (3) @(negedge Clk);
      #1;
      chk("reset_state", 64'(act), 64'(mk(0, 0, 0, 14'h0, 0, 4'd0, 6'h0, 5'h1F, 3'd0, 3'd0)));

      do_instr(8'h10, 1'b0, 1'b0, 0, mk(1, 0, 0, 14'h0000, 0, 4'd0, 6'h00, 5'h0, 3'd0, 3'd0), "first_fetch", 7);
      do_instr(8'h10, 1'b0, 1'b0, 4, mk(0, 0, 0, 14'h0004, 0, 4'd2, 6'h01, 5'h0, 3'd0, 3'd0), "ldac_2", 7);
      do_instr(8'h10, 1'b0, 1'b0, 5, mk(0, 1, 0, 14'h0000, 0, 4'd0, 6'h00, 5'h0, 3'd0, 3'd0), "ldac_3", -1);
      do_instr(8'h10, 1'b0, 1'b0, 6, mk(0, 0, 0, 14'h0008, 0, 4'd3, 6'h00, 5'h0, 3'd0, 3'd0), "ldac_4", -1);
      do_instr(8'h20, 1'b0, 1'b0, 5, mk(0, 0, 1, 14'h0000, 0, 4'd4, 6'h00, 5'h0, 3'd0, 3'd0), "stac_3", 6);
      do_instr(8'h53, 1'b1, 1'b0, 3, mk(0, 0, 0, 14'h1000, 0, 4'd7, 6'h00, 5'h0, 3'd0, 3'd1), "alu_1", 5);
      do_instr(8'h53, 1'b0, 1'b0, 4, mk(0, 0, 0, 14'h0008, 0, 4'd13, 6'h00, 5'h0, 3'd0, 3'd0), "alu_2", -1);
      do_instr(8'hB0, 1'b0, 1'b0, 3, mk(0, 0, 0, 14'h0000, 0, 4'd0, 6'h01, 5'h0, 3'd0, 3'd0), "jzn_1", 4);
      do_instr(8'hB0, 1'b1, 1'b0, 4, mk(0, 0, 0, 14'h0001, 0, 4'd2, 6'h00, 5'h0, 3'd0, 3'd0), "j_2", 5);
      do_instr(8'h73, 1'b0, 1'b0, -1, none, "mul", MUL_EN ? 5 : 4);
      do_instr(8'h85, 1'b0, 1'b0, -1, none, "incr_bad", 4);
      do_instr(8'h94, 1'b0, 1'b0, 3, mk(0, 0, 0, 14'h0000, 0, 4'd0, 6'h00, 5'h10, 3'd0, 3'd0), "clr_r4", 4);
      do_instr(8'hC8, 1'b0, 1'b0, 3, mk(0, 0, 0, 14'h0000, 0, 4'd0, 6'h00, 5'h0, 3'd7, 3'd2), "cmp_r8", 4);
      do_instr(8'h38, 1'b0, 1'b0, 3, mk(0, 0, 0, 14'h0800, 0, 4'd4, 6'h00, 5'h0, 3'd0, 3'd0), "mvr_r8", 4);
      do_instr(8'h30, 1'b0, 1'b0, -1, none, "mvr_bad", 4);
      do_instr(8'hD0, 1'b0, 1'b0, 3, mk(0, 1, 0, 14'h0000, 1, 4'd0, 6'h00, 5'h0, 3'd0, 3'd0), "ldi_1", 5);
      do_instr(8'hF0, 1'b0, 1'b0, HALT_CYCLES + 2, none, "halt", HALT_CYCLES + 3);
      do_instr(8'h10, 1'b0, 1'b1, -1, none, "ldac_abort", -1);

      for (int i = 0; i < 300; i++) begin
         logic [7:0] ir;
         ir = 8'($urandom);
         do_instr(ir, 1'($urandom), ($urandom_range(29, 0) == 0), -1, none, "rand", -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
